// File: rtl/mem_sched_rv32i.sv
// Memory scheduler sequencing RV32I fetch/execute/data/write-back over one shared port.
// Optional bus-timeout watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_sched_rv32i #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        halt_i,
   input  logic [31:0] pc_i,
   output logic [31:0] ir_o,
   input  logic        cu_load_i,
   input  logic        cu_store_i,
   input  logic [31:0] d_addr_i,
   input  logic [31:0] d_wdata_i,
   input  logic [3:0]  d_be_i,
   output logic [31:0] d_rdata_o,
   output logic        commit_o,
   output logic        busy_o,
   output logic        err_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic [3:0]  mem_be_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_rdata_i,
   output logic [2:0]  state_o
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_EXEC  = 3'd2;
   localparam logic [2:0] S_DATA  = 3'd3;
   localparam logic [2:0] S_WB    = 3'd4;
   localparam logic [2:0] S_ERROR = 3'd5;

   localparam logic [31:0] NOP = 32'h0000_0013;

   // Handshake: a request is held stable from the cycle mem_req_o rises until
   // the rising edge at which mem_ack_i=1 is sampled; acks without a request are ignored.
   logic [2:0]  state, state_nxt;
   logic [31:0] ir_q, rdata_q, addr_q, wdata_q;
   logic [3:0]  be_q;
   logic        we_q;
   logic        is_mem;
   logic        in_req;
   logic        timeout_hit;

   assign is_mem = cu_load_i | cu_store_i;
   assign in_req = (state == S_FETCH) || (state == S_DATA);

`ifdef ARB_TIMEOUT_EN
   localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
   logic [CW-1:0] wait_cnt;
   logic          err_q;

   assign timeout_hit = in_req && !mem_ack_i && (wait_cnt == CW'(TIMEOUT - 1));

   // Counter rests at zero outside request states, so every FETCH/DATA entry starts fresh.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= '0;
         err_q    <= 1'b0;
      end else begin
         if (!in_req || mem_ack_i) wait_cnt <= '0;
         else                      wait_cnt <= wait_cnt + CW'(1);
         if (timeout_hit) err_q <= 1'b1;
      end
   end
   assign err_o = err_q;
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT != 0);
   assign timeout_hit    = 1'b0;
   assign err_o          = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (!halt_i) state_nxt = S_FETCH;
         S_FETCH: if (mem_ack_i) state_nxt = S_EXEC;
                  else if (timeout_hit) state_nxt = S_ERROR;
         S_EXEC:  if (is_mem) state_nxt = S_DATA;
                  else state_nxt = halt_i ? S_IDLE : S_FETCH;
         S_DATA:  if (mem_ack_i) state_nxt = S_WB;
                  else if (timeout_hit) state_nxt = S_ERROR;
         S_WB:    state_nxt = halt_i ? S_IDLE : S_FETCH;
         S_ERROR: state_nxt = S_ERROR;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         ir_q    <= NOP;
         rdata_q <= 32'h0;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         be_q    <= 4'h0;
         we_q    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == S_FETCH && mem_ack_i) ir_q <= mem_rdata_i;
         // Store wins when the decoder flags both load and store.
         if (state == S_EXEC && is_mem) begin
            addr_q  <= d_addr_i;
            wdata_q <= d_wdata_i;
            be_q    <= d_be_i;
            we_q    <= cu_store_i;
         end
         if (state == S_DATA && mem_ack_i && !we_q) rdata_q <= mem_rdata_i;
      end
   end

   assign mem_req_o   = in_req;
   assign mem_we_o    = (state == S_DATA) && we_q;
   assign mem_addr_o  = (state == S_FETCH) ? pc_i :
                        (state == S_DATA)  ? addr_q : 32'h0;
   assign mem_wdata_o = (state == S_DATA) ? wdata_q : 32'h0;
   assign mem_be_o    = (state == S_FETCH) ? 4'hF :
                        (state == S_DATA)  ? be_q : 4'h0;
   assign commit_o    = ((state == S_EXEC) && !is_mem) || (state == S_WB);
   assign busy_o      = (state != S_IDLE);
   assign ir_o        = ir_q;
   assign d_rdata_o   = rdata_q;
   assign state_o     = state;

endmodule

// File: tb/tb_mem_sched_rv32i.sv
// Self-checking bench for mem_sched_rv32i: vector table, bus scoreboard and corner sequences.
// The timeout section follows ARB_TIMEOUT_EN as the RTL does.
`timescale 1ns/1ps
module tb_mem_sched_rv32i;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_EXEC  = 3'd2;
   localparam logic [2:0] S_DATA  = 3'd3;
   localparam logic [2:0] S_ERROR = 3'd5;
   localparam int TW = 69;

   logic        clk = 1'b0, rst_n = 1'b0, halt_i = 1'b1;
   logic [31:0] pc_i = 32'h0, ir_o, d_addr_i = 32'h0, d_wdata_i = 32'h0, d_rdata_o;
   logic        cu_load_i, cu_store_i, commit_o, busy_o, err_o;
   logic [3:0]  d_be_i = 4'h0, mem_be_o;
   logic        mem_req_o, mem_we_o, mem_ack_i = 1'b0;
   logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i = 32'h0;
   logic [2:0]  state_o;

   // Bench-side decoder, with an override that raises load and store together.
   logic force_both = 1'b0;
   assign cu_load_i  = (ir_o[6:0] == 7'h03) | force_both;
   assign cu_store_i = (ir_o[6:0] == 7'h23) | force_both;

   mem_sched_rv32i #(.TIMEOUT(4)) dut (
      .clk(clk), .rst_n(rst_n), .halt_i(halt_i), .pc_i(pc_i), .ir_o(ir_o),
      .cu_load_i(cu_load_i), .cu_store_i(cu_store_i), .d_addr_i(d_addr_i),
      .d_wdata_i(d_wdata_i), .d_be_i(d_be_i), .d_rdata_o(d_rdata_o),
      .commit_o(commit_o), .busy_o(busy_o), .err_o(err_o), .mem_req_o(mem_req_o),
      .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_be_o(mem_be_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
      .state_o(state_o)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   int checks = 0, errors = 0;
   logic [TW-1:0] exp_q[$];        // {we, addr, be, wdata}
   int            commit_log[$];
   logic [31:0]   imem [logic [31:0]];
   logic [31:0]   ld_data = 32'h0;
   int            fetch_waits = 0, data_waits = 0, wcnt = 0;
   bit            no_ack = 1'b0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp_v, $time);
      end
   endtask

   // Memory responder and bus monitor: compares every request cycle against the
   // head of exp_q, acks after the programmed wait count, and logs commit cycles.
   always @(negedge clk) begin
      logic [TW-1:0] t;
      int wn;
      if (mem_req_o) begin
         wn = (state_o == S_FETCH) ? fetch_waits : data_waits;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_req: addr %h we %b, expected no request", mem_addr_o, mem_we_o);
            mem_ack_i = 1'b0;
         end else begin
            t = exp_q[0];
            if (mem_we_o !== t[68] || mem_addr_o !== t[67:36] || mem_be_o !== t[35:32] ||
                (t[68] && mem_wdata_o !== t[31:0])) begin
               errors++;
               $display("FAIL bus_txn: got we=%b addr=%h be=%h wd=%h expected we=%b addr=%h be=%h wd=%h",
                        mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o, t[68], t[67:36], t[35:32], t[31:0]);
            end
            if (!no_ack && wcnt >= wn) begin
               mem_ack_i   = 1'b1;
               mem_rdata_i = (state_o == S_FETCH) ?
                             (imem.exists(mem_addr_o) ? imem[mem_addr_o] : 32'h13) : ld_data;
               void'(exp_q.pop_front());
               wcnt = 0;
            end else begin
               mem_ack_i = 1'b0;
               wcnt++;
            end
         end
      end else begin
         mem_ack_i = 1'b0;
         wcnt = 0;
         checks++;
         if (mem_we_o !== 1'b0 || mem_be_o !== 4'h0) begin
            errors++;
            $display("FAIL idle_bus: got we=%b be=%h expected 0/0", mem_we_o, mem_be_o);
         end
      end
      if (commit_o) commit_log.push_back(cyc);
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   typedef struct {
      logic [31:0] pc, instr, daddr, wdata, ldata;
      logic [3:0]  be;
      int          fw, dw;
      bit          both, exp_mem, exp_we;
      int          exp_lat;
   } vec_t;

   task automatic run_vec(input vec_t v, input string nm);
      int c0, n0, k;
      bit seen_exec;
      pc_i = v.pc; imem[v.pc] = v.instr;
      d_addr_i = v.daddr; d_wdata_i = v.wdata; d_be_i = v.be;
      fetch_waits = v.fw; data_waits = v.dw; ld_data = v.ldata; force_both = v.both;
      exp_q.push_back({1'b0, v.pc, 4'hF, 32'h0});
      if (v.exp_mem) exp_q.push_back({v.exp_we, v.daddr, v.be, v.wdata});
      n0 = commit_log.size(); c0 = cyc; seen_exec = 1'b0; k = 0;
      halt_i = 1'b0;
      tick();
      halt_i = 1'b1;
      while (1) begin
         if (state_o == S_EXEC && !seen_exec) begin
            check({nm, "_ir"}, ir_o, v.instr);
            seen_exec = 1'b1;
         end
         // The core may move its data inputs once the access is snapshotted.
         if (state_o == S_DATA) begin
            d_addr_i = $urandom; d_wdata_i = $urandom; d_be_i = 4'($urandom_range(0, 15));
         end
         if (commit_log.size() != n0 || k >= 100) break;
         tick();
         k++;
      end
      if (commit_log.size() == n0) check({nm, "_commit_seen"}, 32'd0, 32'd1);
      else check({nm, "_latency"}, commit_log[n0] - c0, v.exp_lat);
      tick();
      check({nm, "_one_commit"}, commit_log.size() - n0, 32'd1);
      check({nm, "_idle"}, {28'h0, busy_o, state_o}, {29'h0, S_IDLE});
      if (v.exp_mem && !v.exp_we) check({nm, "_rdata"}, d_rdata_o, v.ldata);
      force_both = 1'b0;
   endtask

   // ---------------- test ----------------
   vec_t vecs[7];

   initial begin
      int c0, n0, k, bad;
      vecs[0] = '{pc:32'h40, instr:32'h00100093, daddr:0, wdata:0, ldata:0, be:4'h0, fw:0, dw:0, both:0, exp_mem:0, exp_we:0, exp_lat:2};
      vecs[1] = '{pc:32'h44, instr:32'h00500113, daddr:0, wdata:0, ldata:0, be:4'h0, fw:2, dw:0, both:0, exp_mem:0, exp_we:0, exp_lat:4};
      vecs[2] = '{pc:32'h10, instr:32'h0000A183, daddr:32'h100, wdata:0, ldata:32'hDEADBEEF, be:4'hF, fw:0, dw:2, both:0, exp_mem:1, exp_we:0, exp_lat:6};
      vecs[3] = '{pc:32'h20, instr:32'h00208023, daddr:32'h203, wdata:32'hAB000000, ldata:0, be:4'b1000, fw:0, dw:0, both:0, exp_mem:1, exp_we:1, exp_lat:4};
      vecs[4] = '{pc:32'h24, instr:32'h0020A023, daddr:32'h300, wdata:32'h12345678, ldata:0, be:4'hF, fw:1, dw:3, both:0, exp_mem:1, exp_we:1, exp_lat:8};
      vecs[5] = '{pc:32'h50, instr:32'h00009183, daddr:32'h104, wdata:0, ldata:32'h0000BEEF, be:4'h3, fw:1, dw:0, both:0, exp_mem:1, exp_we:0, exp_lat:5};
      vecs[6] = '{pc:32'h54, instr:32'h00000013, daddr:32'h500, wdata:32'h5A5A5A5A, ldata:0, be:4'hF, fw:0, dw:0, both:1, exp_mem:1, exp_we:1, exp_lat:4};

      // Reset values
      repeat (3) tick();
      check("rst_ir", ir_o, 32'h13);
      check("rst_outs", {26'h0, commit_o, busy_o, err_o, mem_req_o, mem_we_o, 1'b0}, 32'h0);
      check("rst_bus", mem_addr_o | mem_wdata_o | {28'h0, mem_be_o} | d_rdata_o, 32'h0);
      rst_n = 1'b1;
      tick();
      check("halt_idle", {29'h0, state_o}, {29'h0, S_IDLE});

      foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Back-to-back stream: two ADDIs then a store halted in EXEC
      imem[32'h0] = 32'h00100093; imem[32'h4] = 32'h00200113; imem[32'h8] = 32'h0020A223;
      pc_i = 32'h0; d_addr_i = 32'h404; d_wdata_i = 32'hCAFE0000; d_be_i = 4'hF;
      fetch_waits = 0; data_waits = 0;
      exp_q.push_back({1'b0, 32'h0, 4'hF, 32'h0});
      exp_q.push_back({1'b0, 32'h4, 4'hF, 32'h0});
      exp_q.push_back({1'b0, 32'h8, 4'hF, 32'h0});
      exp_q.push_back({1'b1, 32'h404, 4'hF, 32'hCAFE0000});
      n0 = commit_log.size(); c0 = cyc; k = 0;
      halt_i = 1'b0;
      while (commit_log.size() < n0 + 3 && k < 60) begin
         tick(); k++;
         if (state_o == S_EXEC) begin
            check("stream_ir", ir_o, imem[pc_i]);
            if (pc_i == 32'h8) halt_i = 1'b1;
         end
         if (commit_o) pc_i = pc_i + 32'd4;
      end
      check("stream_commits", commit_log.size() - n0, 32'd3);
      if (commit_log.size() >= n0 + 3) begin
         check("stream_c1", commit_log[n0]     - c0, 32'd2);
         check("stream_c2", commit_log[n0 + 1] - c0, 32'd4);
         check("stream_c3", commit_log[n0 + 2] - c0, 32'd8);
      end
      repeat (20) tick();
      check("stream_halted", {28'h0, busy_o, state_o}, {29'h0, S_IDLE});
      check("stream_no_extra", commit_log.size() - n0, 32'd3);

      // Reset in the middle of a waited load
      pc_i = 32'h60; imem[32'h60] = 32'h0000A183; d_addr_i = 32'h180; d_be_i = 4'hF;
      fetch_waits = 0; data_waits = 10; ld_data = 32'h11111111;
      exp_q.push_back({1'b0, 32'h60, 4'hF, 32'h0});
      exp_q.push_back({1'b0, 32'h180, 4'hF, 32'h0});
      n0 = commit_log.size(); k = 0;
      halt_i = 1'b0; tick(); halt_i = 1'b1;
      while (state_o != S_DATA && k < 20) begin tick(); k++; end
      check("rst_mid_in_data", {29'h0, state_o}, {29'h0, S_DATA});
      repeat (2) tick();
      rst_n = 1'b0;
      #1;
      check("rstmid_req", {31'h0, mem_req_o}, 32'h0);
      check("rstmid_outs", {27'h0, commit_o, busy_o, err_o, mem_we_o, 1'b0}, 32'h0);
      check("rstmid_bus", mem_addr_o | mem_wdata_o | {28'h0, mem_be_o} | d_rdata_o, 32'h0);
      check("rstmid_ir", ir_o, 32'h13);
      repeat (2) tick();
      exp_q.delete();
      rst_n = 1'b1;
      tick();
      check("rstmid_no_commit", commit_log.size() - n0, 32'd0);
      run_vec('{pc:32'h70, instr:32'h00300193, daddr:0, wdata:0, ldata:0, be:4'h0, fw:0, dw:0, both:0, exp_mem:0, exp_we:0, exp_lat:2}, "restart");

      // Memory that never acknowledges
      pc_i = 32'h80; no_ack = 1'b1;
      exp_q.push_back({1'b0, 32'h80, 4'hF, 32'h0});
      halt_i = 1'b0; tick(); halt_i = 1'b1;
`ifdef ARB_TIMEOUT_EN
      k = 0;
      while (mem_req_o && k < 50) begin tick(); k++; end
      check("to_req_cycles", k, 32'd4);
      check("to_req_err", {30'h0, mem_req_o, err_o}, 32'h1);
      bad = 0;
      repeat (20) begin tick(); if (state_o !== S_ERROR || err_o !== 1'b1 || mem_req_o !== 1'b0) bad++; end
      check("to_stuck", bad, 32'd0);
`else
      bad = 0;
      repeat (1000) begin tick(); if (mem_req_o !== 1'b1 || err_o !== 1'b0) bad++; end
      check("nowait_hold", bad, 32'd0);
`endif
      rst_n = 1'b0; #1;
      exp_q.delete(); no_ack = 1'b0;
      check("final_rst_err", {30'h0, mem_req_o, err_o}, 32'h0);
      tick(); rst_n = 1'b1; tick();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
